// File: rtl/cmac_usplus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmac_usplus_pkg
//  Description : Shared constants, report record, FSM state type and the
//                length-to-report helper for the CMAC RX frame collector.
//  Revision    : 1.0  initial release
// ============================================================================
package cmac_usplus_pkg;

    localparam int BEAT_BYTES = 64;
    localparam int MAX_BYTES  = 16383;
    localparam int CNT_W      = 16;
    localparam int BYTES_W    = 14;

    // One frame report as stored in the report queue
    typedef struct packed {
        logic               err;
        logic [BYTES_W-1:0] bytes;
    } rpt_t;

    // Frame tracking state
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    // Turn a saturated 16-bit frame length into a report; lengths beyond
    // the reportable range are clamped and always flagged bad.
    function automatic rpt_t make_report(input logic [CNT_W-1:0] len, input logic err);
        rpt_t r;
        if (len > CNT_W'(MAX_BYTES)) begin
            r.err   = 1'b1;
            r.bytes = BYTES_W'(MAX_BYTES);
        end else begin
            r.err   = err;
            r.bytes = len[BYTES_W-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmac_usplus_len_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cmac_usplus_len_fifo
//  Description : Register-based first-word-fall-through report queue with two
//                ordered write ports (a truncated frame and a new single-beat
//                frame can complete in the same cycle). A push that finds no
//                room, after accounting for a same-cycle pop, is rejected.
//  Revision    : 1.0  initial release
// ============================================================================
module cmac_usplus_len_fifo
    import cmac_usplus_pkg::*;
#(
    parameter int LEN_DEPTH = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_wr0_en,
    input  rpt_t i_wr0_data,
    input  logic i_wr1_en,
    input  rpt_t i_wr1_data,
    output logic o_wr1_accept,
    input  logic i_rd_en,
    output rpt_t o_rd_data,
    output logic o_empty,
    output logic o_full
);

    localparam int AW = $clog2(LEN_DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(LEN_DEPTH);

    rpt_t          r_mem [LEN_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_pop;
    logic [AW:0]   w_space;
    logic          w_wr0_accept;
    logic [1:0]    w_n_push;
    logic [AW-1:0] w_wr1_addr;

    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == c_depth);
    assign w_pop        = i_rd_en & ~o_empty;
    // Free slots this cycle; a pop frees its slot for a same-cycle push
    assign w_space      = c_depth - r_count + (AW+1)'(w_pop);
    assign w_wr0_accept = i_wr0_en & (w_space != '0);
    assign o_wr1_accept = i_wr1_en & (w_wr0_accept ? (w_space >= (AW+1)'(2))
                                                   : (w_space != '0));
    assign w_n_push     = 2'(w_wr0_accept) + 2'(o_wr1_accept);
    assign w_wr1_addr   = r_wr_ptr + AW'(w_wr0_accept);
    assign o_rd_data    = r_mem[r_rd_ptr];

    // Storage write; entries are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_wr0_accept) r_mem[r_wr_ptr]   <= i_wr0_data;
        if (o_wr1_accept) r_mem[w_wr1_addr] <= i_wr1_data;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + (AW+1)'(w_n_push) - (AW+1)'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmac_usplus_collector.sv
`default_nettype none
// ============================================================================
//  Module      : cmac_usplus_collector
//  Description : Registers the CMAC RX beat stream through unchanged, tracks
//                frame boundaries to measure each frame's byte length, queues
//                {err, bytes} reports behind a valid/ready interface and keeps
//                good/bad/drop/protocol-error statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module cmac_usplus_collector
    import cmac_usplus_pkg::*;
#(
    parameter int LEN_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [511:0] rx_data,
    input  logic         rx_valid,
    input  logic         rx_sop,
    input  logic         rx_eop,
    input  logic [7:0]   rx_mty,
    input  logic         rx_err,
    output logic [511:0] dout_data,
    output logic         dout_valid,
    output logic         dout_sop,
    output logic         dout_eop,
    output logic [7:0]   dout_mty,
    output logic         rpt_valid,
    output logic [13:0]  rpt_bytes,
    output logic         rpt_err,
    input  logic         rpt_ready,
    output logic [31:0]  good_frames,
    output logic [31:0]  bad_frames,
    output logic [15:0]  drop_count,
    output logic [15:0]  proto_err_count
);

    localparam logic [6:0] c_beat_bytes = 7'(BEAT_BYTES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    logic [6:0]       w_beat_len;
    logic [CNT_W:0]   w_sum_wide;
    logic [CNT_W-1:0] w_sum_sat;

    logic             w_cmp_a_valid;
    rpt_t             w_cmp_a;
    logic             w_cmp_b_valid;
    rpt_t             w_cmp_b;
    logic             w_proto_err;

    logic             r_cmp_a_valid;
    rpt_t             r_cmp_a;
    logic             r_cmp_b_valid;
    rpt_t             r_cmp_b;

    rpt_t             w_rd_data;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_wr1_accept;
    logic             w_pop;
    logic             w_drop_a;
    logic             w_drop_b;
    logic [1:0]       w_good_inc;
    logic [1:0]       w_bad_inc;
    logic [1:0]       w_drop_inc;

    // Bytes carried by the current beat and the saturating running total
    assign w_beat_len = rx_eop ? (c_beat_bytes - {1'b0, rx_mty[5:0]}) : c_beat_bytes;
    assign w_sum_wide = {1'b0, r_count} + (CNT_W+1)'(w_beat_len);
    assign w_sum_sat  = w_sum_wide[CNT_W] ? {CNT_W{1'b1}} : w_sum_wide[CNT_W-1:0];

    // Pass-through beat control, cleared by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
        end else begin
            dout_valid <= rx_valid;
            dout_sop   <= rx_sop;
            dout_eop   <= rx_eop;
        end
    end

    // Pass-through beat payload, no reset needed
    always_ff @(posedge clk) begin
        dout_data <= rx_data;
        dout_mty  <= rx_mty;
    end

    // FSM state and running byte count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // FSM next state: any sop restarts a frame, eop always closes it
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (rx_valid) begin
            if (rx_sop) begin
                if (rx_eop) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_state_nxt = IN_FRAME;
                    w_count_nxt = CNT_W'(BEAT_BYTES);
                end
            end else if (r_state == IN_FRAME) begin
                if (rx_eop) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = w_sum_sat;
                end
            end
        end
    end

    // FSM outputs: up to two completions per beat (truncated + new single-beat)
    always_comb begin
        w_cmp_a_valid = 1'b0;
        w_cmp_a       = '0;
        w_cmp_b_valid = 1'b0;
        w_cmp_b       = '0;
        w_proto_err   = 1'b0;
        if (rx_valid) begin
            if (r_state == IN_FRAME) begin
                if (rx_sop) begin
                    w_cmp_a_valid = 1'b1;
                    w_cmp_a       = make_report(r_count, 1'b1);
                    if (rx_eop) begin
                        w_cmp_b_valid = 1'b1;
                        w_cmp_b       = make_report(CNT_W'(w_beat_len), rx_err);
                    end
                end else if (rx_eop) begin
                    w_cmp_a_valid = 1'b1;
                    w_cmp_a       = make_report(w_sum_sat, rx_err);
                end
            end else begin
                if (rx_sop) begin
                    if (rx_eop) begin
                        w_cmp_a_valid = 1'b1;
                        w_cmp_a       = make_report(CNT_W'(w_beat_len), rx_err);
                    end
                end else begin
                    w_proto_err = 1'b1;
                end
            end
        end
    end

    // Completion stage: reports are written to the queue one edge later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmp_a_valid <= 1'b0;
            r_cmp_a       <= '0;
            r_cmp_b_valid <= 1'b0;
            r_cmp_b       <= '0;
        end else begin
            r_cmp_a_valid <= w_cmp_a_valid;
            r_cmp_a       <= w_cmp_a;
            r_cmp_b_valid <= w_cmp_b_valid;
            r_cmp_b       <= w_cmp_b;
        end
    end

    cmac_usplus_len_fifo #(
        .LEN_DEPTH (LEN_DEPTH)
    ) u_len_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_wr0_en     (r_cmp_a_valid),
        .i_wr0_data   (r_cmp_a),
        .i_wr1_en     (r_cmp_b_valid),
        .i_wr1_data   (r_cmp_b),
        .o_wr1_accept (w_wr1_accept),
        .i_rd_en      (rpt_ready),
        .o_rd_data    (w_rd_data),
        .o_empty      (w_fifo_empty),
        .o_full       (w_fifo_full)
    );

    assign rpt_valid = ~w_fifo_empty;
    assign rpt_bytes = w_rd_data.bytes;
    assign rpt_err   = w_rd_data.err;
    assign w_pop     = rpt_valid & rpt_ready;

    // The first push is lost only if the queue is full and nothing leaves
    assign w_drop_a   = r_cmp_a_valid & w_fifo_full & ~w_pop;
    assign w_drop_b   = r_cmp_b_valid & ~w_wr1_accept;
    assign w_good_inc = 2'(r_cmp_a_valid & ~r_cmp_a.err) + 2'(r_cmp_b_valid & ~r_cmp_b.err);
    assign w_bad_inc  = 2'(r_cmp_a_valid &  r_cmp_a.err) + 2'(r_cmp_b_valid &  r_cmp_b.err);
    assign w_drop_inc = 2'(w_drop_a) + 2'(w_drop_b);

    // Statistics counters, all wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            good_frames     <= '0;
            bad_frames      <= '0;
            drop_count      <= '0;
            proto_err_count <= '0;
        end else begin
            good_frames     <= good_frames + 32'(w_good_inc);
            bad_frames      <= bad_frames + 32'(w_bad_inc);
            drop_count      <= drop_count + 16'(w_drop_inc);
            proto_err_count <= proto_err_count + 16'(w_proto_err);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmac_usplus_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmac_usplus_collector
//  Description : Self-checking bench for the CMAC RX frame collector with a
//                queue-level reference model of frame lengths and reports.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cmac_usplus_collector;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [511:0] rx_data = '0;
    logic         rx_valid = 1'b0;
    logic         rx_sop = 1'b0;
    logic         rx_eop = 1'b0;
    logic [7:0]   rx_mty = '0;
    logic         rx_err = 1'b0;
    logic         rpt_ready = 1'b0;
    logic [511:0] dout_data;
    logic         dout_valid, dout_sop, dout_eop;
    logic [7:0]   dout_mty;
    logic         rpt_valid;
    logic [13:0]  rpt_bytes;
    logic         rpt_err;
    logic [31:0]  good_frames, bad_frames;
    logic [15:0]  drop_count, proto_err_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cmac_usplus_collector #(.LEN_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_mty(rx_mty), .rx_err(rx_err),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_sop(dout_sop),
        .dout_eop(dout_eop), .dout_mty(dout_mty),
        .rpt_valid(rpt_valid), .rpt_bytes(rpt_bytes), .rpt_err(rpt_err), .rpt_ready(rpt_ready),
        .good_frames(good_frames), .bad_frames(bad_frames),
        .drop_count(drop_count), .proto_err_count(proto_err_count)
    );

    // ---------------- reference model (queue level) ----------------
    typedef struct { int bytes; bit err; } rep_t;
    rep_t         m_fifo[$];
    rep_t         m_pend[$];
    rep_t         m_new[$];
    bit           m_open = 1'b0;
    int           m_cnt = 0;
    logic [31:0]  m_good = '0, m_bad = '0;
    logic [15:0]  m_drop = '0, m_proto = '0;
    logic         p_valid = 1'b0, p_sop = 1'b0, p_eop = 1'b0;
    logic [7:0]   p_mty = '0;
    logic [511:0] p_data = '0;

    function automatic rep_t mk(input int len, input bit err);
        rep_t r;
        r.bytes = (len > 16383) ? 16383 : len;
        r.err   = err || (len > 16383);
        return r;
    endfunction

    always begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_fifo.delete(); m_pend.delete();
            m_open = 1'b0; m_cnt = 0;
            m_good = '0; m_bad = '0; m_drop = '0; m_proto = '0;
            p_valid = 1'b0; p_sop = 1'b0; p_eop = 1'b0;
        end else begin
            if (m_fifo.size() > 0 && rpt_ready) void'(m_fifo.pop_front());
            foreach (m_pend[i]) begin
                if (m_pend[i].err) m_bad++; else m_good++;
                if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pend[i]);
                else m_drop++;
            end
            m_new.delete();
            if (rx_valid) begin
                if (rx_sop) begin
                    if (m_open) m_new.push_back(mk(m_cnt, 1'b1));
                    m_open = 1'b0;
                    if (rx_eop) m_new.push_back(mk(64 - int'(rx_mty[5:0]), rx_err));
                    else begin m_open = 1'b1; m_cnt = 64; end
                end else if (m_open) begin
                    if (rx_eop) begin
                        m_cnt += 64 - int'(rx_mty[5:0]);
                        m_new.push_back(mk(m_cnt, rx_err));
                        m_open = 1'b0;
                    end else begin
                        m_cnt += 64;
                    end
                end else begin
                    m_proto++;
                end
            end
            m_pend = m_new;
            p_valid = rx_valid; p_sop = rx_sop; p_eop = rx_eop;
            p_mty = rx_mty; p_data = rx_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [7:0] m, input logic er);
        @(negedge clk);
        rx_valid = v; rx_sop = s; rx_eop = e; rx_mty = m; rx_err = er;
        for (int i = 0; i < 16; i++) rx_data[i*32 +: 32] = $urandom();
    endtask

    task automatic idle();
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL reset.dout_valid got %b want 0", dout_valid); else n_pass++;
        n_checks++; if (rpt_valid !== 1'b0) $display("FAIL reset.rpt_valid got %b want 0", rpt_valid); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (good_frames !== 32'd0 || bad_frames !== 32'd0)
            $display("FAIL reset.frames got %0d/%0d want 0/0", good_frames, bad_frames); else n_pass++;
        n_checks++; if (drop_count !== 16'd0 || proto_err_count !== 16'd0)
            $display("FAIL reset.errcnt got %0d/%0d want 0/0", drop_count, proto_err_count); else n_pass++;
    endtask

    task automatic test_single_beat();
        logic [511:0] d;
        drive(1, 1, 1, 8'd4, 0);
        d = rx_data;
        @(negedge clk);
        idle();
        n_checks++; if (dout_valid !== 1'b1 || dout_sop !== 1'b1 || dout_eop !== 1'b1)
            $display("FAIL single.dout_ctl got %b%b%b want 111", dout_valid, dout_sop, dout_eop); else n_pass++;
        n_checks++; if (dout_data !== d || dout_mty !== 8'd4)
            $display("FAIL single.dout_payload got mty %0d want 4 (data match %b)", dout_mty, dout_data === d); else n_pass++;
        n_checks++; if (rpt_valid !== 1'b0) $display("FAIL single.early_valid got %b want 0", rpt_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (rpt_valid !== 1'b1 || rpt_bytes !== 14'd60 || rpt_err !== 1'b0)
            $display("FAIL single.report got v%b %0d e%b want v1 60 e0", rpt_valid, rpt_bytes, rpt_err); else n_pass++;
        n_checks++; if (good_frames !== 32'd1) $display("FAIL single.good got %0d want 1", good_frames); else n_pass++;
        rpt_ready = 1'b1;
        @(negedge clk);
        rpt_ready = 1'b0;
        n_checks++; if (rpt_valid !== 1'b0) $display("FAIL single.popped got %b want 0", rpt_valid); else n_pass++;
    endtask

    task automatic test_three_beat();
        drive(1, 1, 0, 8'd0, 0);
        drive(1, 0, 0, 8'd0, 0);
        drive(1, 0, 1, 8'd10, 1);
        @(negedge clk); idle();
        @(negedge clk);
        n_checks++; if (rpt_valid !== 1'b1 || rpt_bytes !== 14'd182 || rpt_err !== 1'b1)
            $display("FAIL three.report got v%b %0d e%b want v1 182 e1", rpt_valid, rpt_bytes, rpt_err); else n_pass++;
        n_checks++; if (bad_frames !== 32'd1) $display("FAIL three.bad got %0d want 1", bad_frames); else n_pass++;
        rpt_ready = 1'b1; @(negedge clk); rpt_ready = 1'b0;
    endtask

    task automatic test_truncated();
        drive(1, 1, 0, 8'd0, 0);
        drive(1, 0, 0, 8'd0, 0);
        drive(1, 1, 1, 8'd0, 0);
        @(negedge clk); idle();
        @(negedge clk);
        n_checks++; if (rpt_valid !== 1'b1 || rpt_bytes !== 14'd128 || rpt_err !== 1'b1)
            $display("FAIL trunc.first got v%b %0d e%b want v1 128 e1", rpt_valid, rpt_bytes, rpt_err); else n_pass++;
        rpt_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rpt_valid !== 1'b1 || rpt_bytes !== 14'd64 || rpt_err !== 1'b0)
            $display("FAIL trunc.second got v%b %0d e%b want v1 64 e0", rpt_valid, rpt_bytes, rpt_err); else n_pass++;
        @(negedge clk);
        rpt_ready = 1'b0;
        n_checks++; if (rpt_valid !== 1'b0) $display("FAIL trunc.empty got %b want 0", rpt_valid); else n_pass++;
    endtask

    task automatic test_fifo_full();
        int n;
        rpt_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) drive(1, 1, 1, 8'(i), 0);
        @(negedge clk); idle();
        repeat (2) @(negedge clk);
        n_checks++; if (drop_count !== 16'd1) $display("FAIL full.drop got %0d want 1", drop_count); else n_pass++;
        rpt_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (rpt_valid !== 1'b1 || rpt_bytes !== 14'(64 - i))
                $display("FAIL full.entry%0d got v%b %0d want v1 %0d", i, rpt_valid, rpt_bytes, 64 - i); else n_pass++;
            @(negedge clk);
        end
        rpt_ready = 1'b0;
        n_checks++; if (rpt_valid !== 1'b0) $display("FAIL full.retained got v%b want 0 after 16", rpt_valid); else n_pass++;
        // refill, then push on the same edge as a pop
        for (int i = 0; i < DEPTH; i++) drive(1, 1, 1, 8'(i), 0);
        drive(1, 1, 1, 8'd40, 0);
        @(negedge clk); idle(); rpt_ready = 1'b1;
        @(negedge clk); rpt_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (drop_count !== 16'd1) $display("FAIL full.pop_push_drop got %0d want 1", drop_count); else n_pass++;
        rpt_ready = 1'b1;
        n = 0;
        while (rpt_valid === 1'b1 && n < 2 * DEPTH) begin
            if (n == DEPTH - 1) begin
                n_checks++; if (rpt_bytes !== 14'd24) $display("FAIL full.last got %0d want 24", rpt_bytes); else n_pass++;
            end
            n++;
            @(negedge clk);
        end
        rpt_ready = 1'b0;
        n_checks++; if (n != DEPTH) $display("FAIL full.count got %0d want %0d", n, DEPTH); else n_pass++;
    endtask

    task automatic test_long_frame();
        drive(1, 1, 0, 8'd0, 0);
        repeat (298) drive(1, 0, 0, 8'd0, 0);
        drive(1, 0, 1, 8'd0, 0);
        @(negedge clk); idle();
        @(negedge clk);
        n_checks++; if (rpt_valid !== 1'b1 || rpt_bytes !== 14'd16383 || rpt_err !== 1'b1)
            $display("FAIL long.report got v%b %0d e%b want v1 16383 e1", rpt_valid, rpt_bytes, rpt_err); else n_pass++;
        rpt_ready = 1'b1; @(negedge clk); rpt_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int n;
        drive(1, 1, 0, 8'd0, 0);
        drive(1, 0, 0, 8'd0, 0);
        @(negedge clk); idle();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_checks++; if (rpt_valid !== 1'b0 || good_frames !== 32'd0)
            $display("FAIL rstmid.cleared got v%b good %0d want v0 good 0", rpt_valid, good_frames); else n_pass++;
        drive(1, 1, 1, 8'd20, 0);
        @(negedge clk); idle();
        @(negedge clk);
        n_checks++; if (rpt_valid !== 1'b1 || rpt_bytes !== 14'd44 || rpt_err !== 1'b0)
            $display("FAIL rstmid.report got v%b %0d e%b want v1 44 e0", rpt_valid, rpt_bytes, rpt_err); else n_pass++;
        rpt_ready = 1'b1;
        n = 0;
        repeat (4) begin
            if (rpt_valid === 1'b1) n++;
            @(negedge clk);
        end
        rpt_ready = 1'b0;
        n_checks++; if (n != 1) $display("FAIL rstmid.reports got %0d want 1", n); else n_pass++;
        n_checks++; if (proto_err_count !== 16'd0) $display("FAIL rstmid.proto got %0d want 0", proto_err_count); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_checks++; if (rpt_valid !== (m_fifo.size() > 0))
                $display("FAIL rand.valid cyc %0d got %b want %b", c, rpt_valid, m_fifo.size() > 0); else n_pass++;
            if (m_fifo.size() > 0) begin
                n_checks++; if (rpt_bytes !== 14'(m_fifo[0].bytes) || rpt_err !== m_fifo[0].err)
                    $display("FAIL rand.report cyc %0d got %0d e%b want %0d e%b", c, rpt_bytes, rpt_err,
                             m_fifo[0].bytes, m_fifo[0].err); else n_pass++;
            end
            n_checks++; if (good_frames !== m_good || bad_frames !== m_bad)
                $display("FAIL rand.frames cyc %0d got %0d/%0d want %0d/%0d", c, good_frames, bad_frames, m_good, m_bad); else n_pass++;
            n_checks++; if (drop_count !== m_drop || proto_err_count !== m_proto)
                $display("FAIL rand.errcnt cyc %0d got %0d/%0d want %0d/%0d", c, drop_count, proto_err_count, m_drop, m_proto); else n_pass++;
            n_checks++; if (dout_valid !== p_valid || dout_sop !== p_sop || dout_eop !== p_eop)
                $display("FAIL rand.dout_ctl cyc %0d got %b%b%b want %b%b%b", c, dout_valid, dout_sop, dout_eop,
                         p_valid, p_sop, p_eop); else n_pass++;
            if (p_valid) begin
                n_checks++; if (dout_data !== p_data || dout_mty !== p_mty)
                    $display("FAIL rand.dout_payload cyc %0d got mty %0d want %0d", c, dout_mty, p_mty); else n_pass++;
            end
            rx_valid  = ($urandom_range(3) != 0);
            rx_sop    = ($urandom_range(3) == 0);
            rx_eop    = ($urandom_range(2) == 0);
            rx_mty    = 8'($urandom());
            rx_err    = ($urandom_range(4) == 0);
            for (int i = 0; i < 16; i++) rx_data[i*32 +: 32] = $urandom();
            rpt_ready = ($urandom_range(2) == 0);
        end
        @(negedge clk); idle(); rpt_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_three_beat();
        test_truncated();
        test_fifo_full();
        test_long_frame();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
